// File: rtl/sobel_div_pkg.sv
// Shared widths, step count and FSM encoding for the 24/11 sequential divider.
package sobel_div_pkg;

    localparam int unsigned DVD_W  = 24;
    localparam int unsigned DSR_W  = 11;
    localparam int unsigned QUO_W  = 13;
    localparam int unsigned STEPS  = 13;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned T_W    = DSR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/sobel_div_step.sv
// One restoring-division step: compare the shifted partial remainder with the divisor.
module sobel_div_step
    import sobel_div_pkg::*;
(
    input  logic [T_W-1:0]   t,
    input  logic [DSR_W-1:0] divisor,
    output logic             q_bit,
    output logic [DSR_W-1:0] rem
);

    logic [T_W-1:0] diff;

    // When t >= divisor the difference is below the divisor, so it fits in DSR_W bits.
    always_comb begin
        diff  = t - T_W'(divisor);
        q_bit = (t >= T_W'(divisor));
        rem   = q_bit ? DSR_W'(diff) : DSR_W'(t);
    end

endmodule

// File: rtl/sobel_udiv_24d11_seq.sv
// Sequential unsigned 24/11 restoring divider with ready/valid handshakes and clock enable.
module sobel_udiv_24d11_seq
    import sobel_div_pkg::*;
#(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd24,
    parameter int unsigned din1_WIDTH = 32'd11,
    parameter int unsigned dout_WIDTH = 32'd13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf
);

    // The datapath is built for the fixed 24/11/13 geometry only.
    if (din0_WIDTH != DVD_W || din1_WIDTH != DSR_W || dout_WIDTH != QUO_W
        || $bits(ID) != 32) begin : g_bad_params
        $error("sobel_udiv_24d11_seq: unsupported parameter set");
    end

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DSR_W-1:0]   prem_q, prem_d;
    logic [QUO_W-1:0]   dvd_q, dvd_d;
    logic [DSR_W-1:0]   dsr_q, dsr_d;
    logic [QUO_W-2:0]   quo_q, quo_d;
    logic [QUO_W-1:0]   dout_q, dout_d;
    logic [DSR_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;

    logic [T_W-1:0]     step_t;
    logic               step_q;
    logic [DSR_W-1:0]   step_rem;

    assign step_t = {prem_q, dvd_q[QUO_W-1]};

    sobel_div_step u_step (
        .t       (step_t),
        .divisor (dsr_q),
        .q_bit   (step_q),
        .rem     (step_rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; everything holds while ce is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;

        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dsr_d = din1;
                        dvd_d = din0[QUO_W-1:0];
                        quo_d = '0;
                        // Upper dividend bits already >= divisor: quotient cannot fit.
                        if (din0[DVD_W-1:QUO_W] >= din1) begin
                            dout_d  = '1;
                            rem_d   = '0;
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            prem_d  = din0[DVD_W-1:QUO_W];
                            cnt_d   = CNT_W'(STEPS - 1);
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    prem_d = step_rem;
                    dvd_d  = {dvd_q[QUO_W-2:0], 1'b0};
                    quo_d  = {quo_q[QUO_W-3:0], step_q};
                    if (cnt_q == '0) begin
                        dout_d  = {quo_q, step_q};
                        rem_d   = step_rem;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dout      = dout_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sobel_udiv_24d11_seq.sv
// Directed-vector bench for the sequential 24/11 divider plus handshake, ce and reset sequences.
module tb_sobel_udiv_24d11_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] din0;
    logic [10:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] dout;
    logic [10:0] rem;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    sobel_udiv_24d11_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [10:0] b;
        logic [12:0] q;
        logic [10:0] r;
        logic        o;
        int          lat;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair with ce high, wait for the result, check it, then take it.
    task automatic run_op(input logic [23:0] a, input logic [10:0] b,
                          input logic [12:0] q, input logic [10:0] r,
                          input logic o, input int lat, input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_dout"}, 32'(dout), 32'(q));
        chk({tag, "_rem"}, 32'(rem), 32'(r));
        chk({tag, "_ovf"}, 32'(ovf), 32'(o));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_taken"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [12:0] held_q;
        logic [10:0] held_r;
        int          en_cnt;
        int          cyc;

        vecs[0] = '{a: 24'd1000,     b: 11'd7,    q: 13'd142,  r: 11'd6,    o: 1'b0, lat: 13};
        vecs[1] = '{a: 24'd16769023, b: 11'd2047, q: 13'd8191, r: 11'd2046, o: 1'b0, lat: 13};
        vecs[2] = '{a: 24'd5,        b: 11'd0,    q: 13'd8191, r: 11'd0,    o: 1'b1, lat: 0};
        vecs[3] = '{a: 24'd16769024, b: 11'd2047, q: 13'd8191, r: 11'd0,    o: 1'b1, lat: 0};
        vecs[4] = '{a: 24'd123456,   b: 11'd789,  q: 13'd156,  r: 11'd372,  o: 1'b0, lat: 13};
        vecs[5] = '{a: 24'd0,        b: 11'd1,    q: 13'd0,    r: 11'd0,    o: 1'b0, lat: 13};
        vecs[6] = '{a: 24'd8191,     b: 11'd1,    q: 13'd8191, r: 11'd0,    o: 1'b0, lat: 13};
        vecs[7] = '{a: 24'd8192,     b: 11'd1,    q: 13'd8191, r: 11'd0,    o: 1'b1, lat: 0};
        vecs[8] = '{a: 24'd100,      b: 11'd200,  q: 13'd0,    r: 11'd100,  o: 1'b0, lat: 13};

        reset     = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        tick();
        tick();
        chk("reset_outputs", {18'd0, dout, ovf}, 32'd0);
        chk("reset_rem", 32'(rem), 32'd0);
        chk("reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Result held under back-pressure; new operands ignored in DONE.
        din0 = 24'd1000;
        din1 = 11'd7;
        in_valid = 1'b1;
        tick();
        din0 = 24'd999999;
        din1 = 11'd3;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd13);
        held_q = dout;
        held_r = rem;
        chk("bp_first_q", 32'(held_q), 32'd142);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_hs", {30'd0, in_ready, out_valid}, 32'd1);
            chk("bp_hold_data", {7'd0, dout, rem, ovf}, {7'd0, 13'd142, 11'd6, 1'b0});
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("bp_no_accept", {30'd0, in_ready, out_valid}, 32'd2);

        // Random ce during RUN: 13 enabled edges regardless of stalls.
        din0 = 24'd123456;
        din1 = 11'd789;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        en_cnt = 0;
        cyc = 0;
        while (!out_valid && cyc < 300) begin
            ce = 1'($urandom_range(0, 1));
            tick();
            if (ce) en_cnt++;
            cyc++;
        end
        chk("ce_enabled_edges", 32'(en_cnt), 32'd13);
        chk("ce_dout", 32'(dout), 32'd156);
        chk("ce_rem", 32'(rem), 32'd372);
        ce = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ce_stall_done", 32'(out_valid), 32'd1);
        ce = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ce_take", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset during RUN step 6 discards the operation.
        din0 = 24'd1000;
        din1 = 11'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("mid_busy", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_data", {7'd0, dout, rem, ovf}, 32'd0);
        chk("mid_reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
        tick();
        #2;
        reset = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("post_reset_quiet", 32'(out_valid), 32'd0);
        end
        run_op(24'd1000, 11'd7, 13'd142, 11'd6, 1'b0, 13, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_udiv_24d11_seq.md
SOBEL_UDIV_24D11_SEQ -- requirements
Module: sobel_udiv_24d11_seq

Interface
REQ-001 SHALL have parameter ID, default 32'd1, instance identifier with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 32'd24, dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 32'd11, divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 32'd13, quotient width.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port ce  input  1  clock enable; low freezes all state.
REQ-008 SHALL have port in_valid  input  1  din0/din1 valid.
REQ-009 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-010 SHALL have port din0  input  24  unsigned dividend.
REQ-011 SHALL have port din1  input  11  unsigned divisor.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port dout  output  13  unsigned quotient.
REQ-015 SHALL have port rem  output  11  unsigned remainder.
REQ-016 SHALL have port ovf  output  1  quotient does not fit in 13 bits, or divisor is zero.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL drive in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 SHALL accept an operand pair on a rising edge with ce=1, in_valid=1, in_ready=1; the pair is captured into internal registers.
REQ-020 SHALL, at acceptance, evaluate ovf = (din0[23:13] >= din1); this covers din1==0.
REQ-021 SHALL, on acceptance with ovf=1, go IDLE->DONE with dout=13'h1FFF, rem=0, ovf=1.
REQ-022 SHALL, on acceptance with ovf=0, go IDLE->RUN with partial remainder = din0[23:13], bit counter = 12, ovf=0.
REQ-023 SHALL perform one restoring step per ce-enabled RUN edge.
REQ-024 SHALL, in each RUN step, form the 12-bit value t = {partial remainder, next dividend bit (MSB first from din0[12:0])}.
REQ-025 SHALL, if t >= divisor, set the quotient bit to 1 and remainder = t - divisor; otherwise set the quotient bit to 0 and remainder = t[10:0].
REQ-026 SHALL go RUN->DONE on the step with counter==0; otherwise decrement the counter.
REQ-027 SHALL have latency, for an acceptance at edge N with continuous ce: out_valid high after edge N+13 (normal) or after edge N (ovf).
REQ-028 SHALL hold dout/rem/ovf stable while out_valid=1 until the result is taken.
REQ-029 SHALL go DONE->IDLE on an edge with ce=1, out_ready=1; no new acceptance occurs on that same edge.
REQ-030 SHALL ignore in_valid outside IDLE.
REQ-031 SHALL make the combinational outputs depend only on registered state.
REQ-032 SHALL ensure ce=0 stalls the FSM, counter and datapath without loss; handshakes do not complete on ce=0 edges.
REQ-033 SHALL hold dout/rem/ovf at their last values outside DONE.

Reset
REQ-034 SHALL, while reset=0, immediately force state=IDLE, counter=0, all datapath registers=0, dout=0, rem=0, ovf=0, out_valid=0, in_ready=1.
REQ-035 SHALL, if reset is asserted mid-RUN or in DONE, discard the operation; no result is emitted after release.
REQ-036 SHALL make the first acceptance possible on the first ce-enabled edge after reset deassertion.

Structure
REQ-037 SHALL place in shared package sobel_div_pkg: dividend/divisor/quotient width constants (24/11/13), step count constant (13), FSM state enum.
REQ-038 SHALL put the restoring-step compare/subtract in a combinational sub-module sobel_div_step (12-bit t and 11-bit divisor in; quotient bit and 11-bit remainder out).

Verification
REQ-039 SHALL cover: din0=1000, din1=7 -> after 13 cycles dout=142, rem=6, ovf=0.
REQ-040 SHALL cover: din0=16769023, din1=2047 -> dout=8191, rem=2046, ovf=0 (max non-overflow).
REQ-041 SHALL cover: din0=5, din1=0 and din0=16769024, din1=2047 -> out_valid one cycle after acceptance, dout=8191, rem=0, ovf=1.
REQ-042 SHALL cover: out_ready=0 for 10 cycles in DONE -> out_valid and outputs held, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-043 SHALL cover: ce toggled randomly during RUN, din0=123456, din1=789 -> dout=156, rem=372, latency = 13 ce-enabled edges.
REQ-044 SHALL cover: reset pulsed at RUN step 6 -> outputs zero immediately, in_ready=1; the next operation 1000/7 completes correctly.
